// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate clock enable, h/v counters,
// and registered syncs, blanking and line/frame strobes aligned to one pixel.
module vga_timing_gen #(
  parameter int H_VIDEO = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIDEO = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int CLK_DIV = 2,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIDEO + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_param_err
    $error("vga_timing_gen: CLK_DIV must be >= 1 and both totals must fit in CW bits");
  end

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // One extra bit so window edges equal to 2^CW still compare correctly.
  localparam logic [CW:0] H_VID = (CW+1)'(H_VIDEO);
  localparam logic [CW:0] H_SS  = (CW+1)'(H_VIDEO + H_FP);
  localparam logic [CW:0] H_SE  = (CW+1)'(H_VIDEO + H_FP + H_SYNC);
  localparam logic [CW:0] V_VID = (CW+1)'(V_VIDEO);
  localparam logic [CW:0] V_SS  = (CW+1)'(V_VIDEO + V_FP);
  localparam logic [CW:0] V_SE  = (CW+1)'(V_VIDEO + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(H_POL);
  localparam logic VS_ON = 1'(V_POL);

  logic [DW-1:0] d;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          tick;

  function automatic logic in_win(input logic [CW:0] c, input logic [CW:0] lo,
                                  input logic [CW:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  // With CLK_DIV=1 the divider is a constant 0 and tick reduces to en.
  assign tick = en && (d == D_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      d           <= '0;
      h           <= '0;
      v           <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      h_sync      <= ~HS_ON;
      v_sync      <= ~VS_ON;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_ce      <= tick;
      line_start  <= tick && (h == '0);
      frame_start <= tick && (h == '0) && (v == '0);
      if (en) begin
        d <= tick ? '0 : d + 1'b1;
      end
      if (tick) begin
        // Outputs decode the pre-advance position so they all describe one pixel.
        pixel_x  <= h;
        pixel_y  <= v;
        video_on <= ({1'b0, h} < H_VID) && ({1'b0, v} < V_VID);
        h_sync   <= in_win({1'b0, h}, H_SS, H_SE) ? HS_ON : ~HS_ON;
        v_sync   <= in_win({1'b0, v}, V_SS, V_SE) ? VS_ON : ~VS_ON;
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random en/rst stimulus on two configurations, checked every clock against a
// model that derives the displayed pixel from the count of enabled clocks.
module tb_vga_timing_gen;

  // Configuration A: divide-by-3, active-low syncs, small raster 19x12.
  localparam int A_HV = 10, A_HF = 3, A_HS = 4, A_HB = 2;
  localparam int A_VV = 5,  A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int A_HP = 0,  A_VP = 0, A_DIV = 3, A_CW = 5;
  // Configuration B: divide-by-1, active-high syncs, raster 15x7 (H_TOTAL near 2^CW).
  localparam int B_HV = 8,  B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 4,  B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_HP = 1,  B_VP = 1, B_DIV = 1, B_CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic            a_ce, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [A_CW-1:0] a_x, a_y;
  logic            b_ce, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [B_CW-1:0] b_x, b_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIDEO(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_VIDEO(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(A_HP), .V_POL(A_VP), .CLK_DIV(A_DIV), .CW(A_CW)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .pix_ce(a_ce), .h_sync(a_hs), .v_sync(a_vs),
    .pixel_x(a_x), .pixel_y(a_y), .video_on(a_von), .line_start(a_ls),
    .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VIDEO(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_VIDEO(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(B_HP), .V_POL(B_VP), .CLK_DIV(B_DIV), .CW(B_CW)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .pix_ce(b_ce), .h_sync(b_hs), .v_sync(b_vs),
    .pixel_x(b_x), .pixel_y(b_y), .video_on(b_von), .line_start(b_ls),
    .frame_start(b_fs)
  );

  // Reference model state: enabled clocks since reset, and whether the last edge ticked.
  int cfg_hv[2], cfg_hf[2], cfg_hs[2], cfg_ht[2];
  int cfg_vv[2], cfg_vf[2], cfg_vs[2], cfg_vt[2];
  int cfg_hp[2], cfg_vp[2], cfg_div[2];
  int en_cnt[2];
  bit last_tick[2];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        en_cnt[i]    = 0;
        last_tick[i] = 1'b0;
      end else if (e) begin
        en_cnt[i]++;
        last_tick[i] = (en_cnt[i] % cfg_div[i]) == 0;
      end else begin
        last_tick[i] = 1'b0;
      end
    end
  endtask

  task automatic check_inst(input int i, input int x, input int y, input bit von,
                            input bit hs, input bit vs, input bit ce, input bit ls,
                            input bit fs);
    int  ticks, p, ex, ey;
    bit  evon, ehs, evs, ece, els, efs;
    string n;
    n     = (i == 0) ? "A" : "B";
    ticks = en_cnt[i] / cfg_div[i];
    ece   = last_tick[i];
    if (ticks == 0) begin
      ex = 0; ey = 0; evon = 0;
      ehs = !cfg_hp[i][0];
      evs = !cfg_vp[i][0];
    end else begin
      p    = ticks - 1;
      ex   = p % cfg_ht[i];
      ey   = (p / cfg_ht[i]) % cfg_vt[i];
      evon = (ex < cfg_hv[i]) && (ey < cfg_vv[i]);
      ehs  = (ex >= cfg_hv[i] + cfg_hf[i] && ex < cfg_hv[i] + cfg_hf[i] + cfg_hs[i])
             ? cfg_hp[i][0] : !cfg_hp[i][0];
      evs  = (ey >= cfg_vv[i] + cfg_vf[i] && ey < cfg_vv[i] + cfg_vf[i] + cfg_vs[i])
             ? cfg_vp[i][0] : !cfg_vp[i][0];
    end
    els = ece && ex == 0;
    efs = ece && ex == 0 && ey == 0;
    chk({n, " pixel_x"},     x,   ex);
    chk({n, " pixel_y"},     y,   ey);
    chk({n, " video_on"},    von, evon);
    chk({n, " h_sync"},      hs,  ehs);
    chk({n, " v_sync"},      vs,  evs);
    chk({n, " pix_ce"},      ce,  ece);
    chk({n, " line_start"},  ls,  els);
    chk({n, " frame_start"}, fs,  efs);
  endtask

  task automatic check_all();
    check_inst(0, int'(a_x), int'(a_y), a_von, a_hs, a_vs, a_ce, a_ls, a_fs);
    check_inst(1, int'(b_x), int'(b_y), b_von, b_hs, b_vs, b_ce, b_ls, b_fs);
  endtask

  initial begin
    int low_left;
    cfg_hv  = '{A_HV, B_HV};  cfg_hf = '{A_HF, B_HF};
    cfg_hs  = '{A_HS, B_HS};
    cfg_ht  = '{A_HV + A_HF + A_HS + A_HB, B_HV + B_HF + B_HS + B_HB};
    cfg_vv  = '{A_VV, B_VV};  cfg_vf = '{A_VF, B_VF};
    cfg_vs  = '{A_VS, B_VS};
    cfg_vt  = '{A_VV + A_VF + A_VS + A_VB, B_VV + B_VF + B_VS + B_VB};
    cfg_hp  = '{A_HP, B_HP};  cfg_vp = '{A_VP, B_VP};
    cfg_div = '{A_DIV, B_DIV};
    en_cnt  = '{0, 0};
    last_tick = '{1'b0, 1'b0};
    low_left = 0;

    // Reset held with en high: reset must win over en.
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      model_edge(rst, en);
    end
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Clean start for one full frame of A so the latency and first pixel are seen.
    repeat (A_DIV * 19 * 12 + 5) begin
      @(posedge clk);
      model_edge(rst, en);
      @(negedge clk);
      check_all();
    end

    // Random run: en dropouts (some long), occasional mid-frame reset pulses.
    repeat (8000) begin
      rst = ($urandom_range(0, 399) == 0);
      if (low_left > 0) begin
        en = 1'b0;
        low_left--;
      end else if ($urandom_range(0, 99) == 0) begin
        en = 1'b0;
        low_left = $urandom_range(1, 40);
      end else begin
        en = ($urandom_range(0, 7) != 0);
      end
      @(posedge clk);
      model_edge(rst, en);
      @(negedge clk);
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
